// File: rtl/host_if_mux.sv
// Host channel initiator: round-robin arbitration of per-core 64-bit requests onto
// one host request register, and routing of host responses back to the owning core.
module host_if_mux #(
    parameter int unsigned nCores = 1,
    localparam int unsigned IDW = (nCores > 1) ? $clog2(nCores) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [nCores-1:0]      core_req_valid,
    output logic [nCores-1:0]      core_req_ready,
    input  logic [nCores*64-1:0]   core_req_data,
    output logic [nCores-1:0]      core_resp_valid,
    input  logic [nCores-1:0]      core_resp_ready,
    output logic [63:0]            core_resp_data,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [IDW-1:0]         req_id,
    output logic [63:0]            req,
    input  logic                   resp_valid,
    output logic                   resp_ready,
    input  logic [IDW-1:0]         resp_id,
    input  logic [63:0]            resp,
    output logic                   bad_id
);

    logic [IDW-1:0]    rr_ptr;
    logic              oreg_free;
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    rr_next;
    logic [63:0]       grant_data;
    int unsigned       slot;

    logic [nCores-1:0] rbuf_v;
    logic [nCores-1:0] rbuf_next;
    logic [63:0]       rdata;
    logic              resp_xfer;
    logic              id_ok;

    // ---------------- request path ----------------
    assign oreg_free = !req_valid || req_ready;

    // Search rr_ptr, rr_ptr+1, ... with explicit wrap so non-power-of-2 counts work.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        slot        = 0;
        for (int unsigned i = 0; i < nCores; i++) begin
            slot = 32'(rr_ptr) + i;
            if (slot >= nCores) begin
                slot = slot - nCores;
            end
            if (!grant_found && core_req_valid[IDW'(slot)]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(slot);
            end
        end
    end

    always_comb begin
        core_req_ready = '0;
        for (int unsigned i = 0; i < nCores; i++) begin
            core_req_ready[i] = oreg_free && grant_found && (grant_idx == IDW'(i));
        end
    end

    assign grant_data = core_req_data[64*int'(grant_idx) +: 64];
    assign rr_next    = (grant_idx == IDW'(nCores - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_valid <= 1'b0;
            req_id    <= '0;
            req       <= '0;
            rr_ptr    <= '0;
        end else if (oreg_free) begin
            if (grant_found) begin
                req_valid <= 1'b1;
                req_id    <= grant_idx;
                req       <= grant_data;
                rr_ptr    <= rr_next;
            end else begin
                req_valid <= 1'b0;
            end
        end
    end

    // ---------------- response path ----------------
    // At most one entry is ever set, so "nothing left unconsumed" covers both cases.
    assign resp_ready = ((rbuf_v & ~core_resp_ready) == '0);
    assign resp_xfer  = resp_valid && resp_ready;
    assign id_ok      = (32'(resp_id) < nCores);

    always_comb begin
        rbuf_next = rbuf_v & ~core_resp_ready;
        for (int unsigned i = 0; i < nCores; i++) begin
            if (resp_xfer && id_ok && (resp_id == IDW'(i))) begin
                rbuf_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rbuf_v <= '0;
            rdata  <= '0;
            bad_id <= 1'b0;
        end else begin
            rbuf_v <= rbuf_next;
            if (resp_xfer && id_ok) begin
                rdata <= resp;
            end
            if (resp_xfer && !id_ok) begin
                bad_id <= 1'b1;
            end
        end
    end

    assign core_resp_valid = rbuf_v;
    assign core_resp_data  = rdata;

endmodule

// File: tb/tb_host_if_mux.sv
// Directed bench for host_if_mux: a 4-core instance driven from a vector table plus
// hand-written stall/reset sequences, and a 3-core instance for out-of-range ids.
module tb_host_if_mux;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // 4-core instance
    logic [3:0]   crv4, cqr4, crsv4, crr4;
    logic [255:0] crd4;
    logic [63:0]  crsd4, q4, rd4;
    logic         qv4, rrdy4, rv4, rsr4, bad4;
    logic [1:0]   qid4, rid4;

    // 3-core instance
    logic [2:0]   crv3, cqr3, crsv3, crr3;
    logic [191:0] crd3;
    logic [63:0]  crsd3, q3, rd3;
    logic         qv3, rrdy3, rv3, rsr3, bad3;
    logic [1:0]   qid3, rid3;

    host_if_mux #(.nCores(4)) u4 (
        .clk(clk), .rstn(rstn),
        .core_req_valid(crv4), .core_req_ready(cqr4), .core_req_data(crd4),
        .core_resp_valid(crsv4), .core_resp_ready(crr4), .core_resp_data(crsd4),
        .req_valid(qv4), .req_ready(rrdy4), .req_id(qid4), .req(q4),
        .resp_valid(rv4), .resp_ready(rsr4), .resp_id(rid4), .resp(rd4),
        .bad_id(bad4)
    );

    host_if_mux #(.nCores(3)) u3 (
        .clk(clk), .rstn(rstn),
        .core_req_valid(crv3), .core_req_ready(cqr3), .core_req_data(crd3),
        .core_resp_valid(crsv3), .core_resp_ready(crr3), .core_resp_data(crsd3),
        .req_valid(qv3), .req_ready(rrdy3), .req_id(qid3), .req(q3),
        .resp_valid(rv3), .resp_ready(rsr3), .resp_id(rid3), .resp(rd3),
        .bad_id(bad3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request-path cycle on u4 with the response side idle.
    task automatic cyc4(input string tag, input logic [3:0] crv, input logic rrdy,
                        input logic [3:0] x_cqr, input logic x_qv,
                        input logic [1:0] x_qid, input logic [63:0] x_q);
        crv4 = crv; rrdy4 = rrdy; rv4 = 1'b0; crr4 = '0;
        #1;
        check({tag, " core_req_ready"}, 64'(cqr4), 64'(x_cqr));
        tick();
        check({tag, " req_valid"}, 64'(qv4), 64'(x_qv));
        if (x_qv) begin
            check({tag, " req_id"}, 64'(qid4), 64'(x_qid));
            check({tag, " req"}, q4, x_q);
        end
    endtask

    typedef struct {
        logic [3:0]  crv;
        logic        rrdy;
        logic [3:0]  crr;
        logic        rv;
        logic [1:0]  rid;
        logic [63:0] rd;
        logic [3:0]  x_cqr;
        logic        x_rsr;
        logic        x_qv;
        logic [1:0]  x_qid;
        logic [63:0] x_q;
        logic [3:0]  x_crv;
        logic [63:0] x_crd;
    } vec_t;

    vec_t vt[18];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin through all cores, then response buffering, then pointer wrap.
        vt[0]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0001, 1'b1, 1'b1, 2'd0, 64'hA0, 4'b0000, 64'h0};
        vt[1]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0010, 1'b1, 1'b1, 2'd1, 64'hA1, 4'b0000, 64'h0};
        vt[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0100, 1'b1, 1'b1, 2'd2, 64'hA2, 4'b0000, 64'h0};
        vt[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b1000, 1'b1, 1'b1, 2'd3, 64'hA3, 4'b0000, 64'h0};
        vt[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0001, 1'b1, 1'b1, 2'd0, 64'hA0, 4'b0000, 64'h0};
        vt[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0000, 1'b1, 1'b0, 2'd0, 64'h0,  4'b0000, 64'h0};
        vt[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 64'h1234, 4'b0000, 1'b1, 1'b0, 2'd0, 64'h0,  4'b0010, 64'h1234};
        vt[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0000, 1'b0, 1'b0, 2'd0, 64'h0,  4'b0010, 64'h1234};
        vt[8]  = '{4'b0000, 1'b1, 4'b0010, 1'b1, 2'd3, 64'h5678, 4'b0000, 1'b1, 1'b0, 2'd0, 64'h0,  4'b1000, 64'h5678};
        vt[9]  = '{4'b0000, 1'b1, 4'b1000, 1'b0, 2'd0, 64'h0,    4'b0000, 1'b1, 1'b0, 2'd0, 64'h0,  4'b0000, 64'h0};
        vt[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 64'hAAAA, 4'b0000, 1'b1, 1'b0, 2'd0, 64'h0,  4'b0100, 64'hAAAA};
        vt[11] = '{4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 64'hBBBB, 4'b0000, 1'b1, 1'b0, 2'd0, 64'h0,  4'b0100, 64'hBBBB};
        vt[12] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 64'h0,    4'b0000, 1'b1, 1'b0, 2'd0, 64'h0,  4'b0000, 64'h0};
        vt[13] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0010, 1'b1, 1'b1, 2'd1, 64'hA1, 4'b0000, 64'h0};
        vt[14] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b1000, 1'b1, 1'b1, 2'd3, 64'hA3, 4'b0000, 64'h0};
        vt[15] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0100, 1'b1, 1'b1, 2'd2, 64'hA2, 4'b0000, 64'h0};
        vt[16] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0001, 1'b1, 1'b1, 2'd0, 64'hA0, 4'b0000, 64'h0};
        vt[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,    4'b0000, 1'b1, 1'b0, 2'd0, 64'h0,  4'b0000, 64'h0};

        for (int i = 0; i < 4; i++) crd4[64*i +: 64] = 64'hA0 + 64'(i);
        for (int i = 0; i < 3; i++) crd3[64*i +: 64] = 64'hC0 + 64'(i);
        crv4 = '0; rrdy4 = 1'b0; crr4 = '0; rv4 = 1'b0; rid4 = '0; rd4 = '0;
        crv3 = '0; rrdy3 = 1'b0; crr3 = '0; rv3 = 1'b0; rid3 = '0; rd3 = '0;

        // Reset state
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
        check("reset req_valid", 64'(qv4), 64'h0);
        check("reset core_resp_valid", 64'(crsv4), 64'h0);
        check("reset bad_id", 64'(bad4), 64'h0);
        check("reset resp_ready", 64'(rsr4), 64'h1);

        // Vector table on u4
        for (int i = 0; i < 18; i++) begin
            crv4 = vt[i].crv; rrdy4 = vt[i].rrdy; crr4 = vt[i].crr;
            rv4 = vt[i].rv; rid4 = vt[i].rid; rd4 = vt[i].rd;
            #1;
            check($sformatf("vec%0d core_req_ready", i), 64'(cqr4), 64'(vt[i].x_cqr));
            check($sformatf("vec%0d resp_ready", i), 64'(rsr4), 64'(vt[i].x_rsr));
            tick();
            check($sformatf("vec%0d req_valid", i), 64'(qv4), 64'(vt[i].x_qv));
            if (vt[i].x_qv) begin
                check($sformatf("vec%0d req_id", i), 64'(qid4), 64'(vt[i].x_qid));
                check($sformatf("vec%0d req", i), q4, vt[i].x_q);
            end
            check($sformatf("vec%0d core_resp_valid", i), 64'(crsv4), 64'(vt[i].x_crv));
            if (vt[i].x_crv != 4'b0000) begin
                check($sformatf("vec%0d core_resp_data", i), crsd4, vt[i].x_crd);
            end
        end
        rv4 = 1'b0; crr4 = '0;

        // Stall: core2 holds the output register while others wait (rr_ptr is 1 here)
        crd4[128 +: 64] = 64'hDEAD_BEEF;
        cyc4("stall load",  4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 64'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            cyc4($sformatf("stall%0d", i), 4'b1011, 1'b0, 4'b0000, 1'b1, 2'd2, 64'hDEAD_BEEF);
        end
        cyc4("stall release", 4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3, 64'hA3);
        cyc4("after stall a", 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 64'hA0);
        cyc4("after stall b", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 64'hA1);
        cyc4("after stall idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0);

        // 3-core instance: out-of-range id, valid id, pointer wrap at core 2
        rv3 = 1'b1; rid3 = 2'd3; rd3 = 64'h99;
        #1;
        check("n3 bad resp_ready", 64'(rsr3), 64'h1);
        tick();
        check("n3 bad core_resp_valid", 64'(crsv3), 64'h0);
        check("n3 bad_id set", 64'(bad3), 64'h1);
        rid3 = 2'd2; rd3 = 64'h55;
        #1;
        check("n3 resp_ready after bad", 64'(rsr3), 64'h1);
        tick();
        check("n3 core_resp_valid id2", 64'(crsv3), 64'h4);
        check("n3 core_resp_data id2", crsd3, 64'h55);
        check("n3 bad_id sticky", 64'(bad3), 64'h1);
        rv3 = 1'b0; crr3 = 3'b100;
        tick();
        check("n3 consumed", 64'(crsv3), 64'h0);
        crr3 = '0; crv3 = 3'b111; rrdy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("n3 rr%0d req_id", i), 64'(qid3), 64'(i % 3));
            check($sformatf("n3 rr%0d req", i), q3, 64'hC0 + 64'(i % 3));
        end
        crv3 = '0;
        tick();
        check("n3 idle req_valid", 64'(qv3), 64'h0);
        check("n3 bad_id still set", 64'(bad3), 64'h1);

        // Reset with a stalled request and a buffered response (rr_ptr is 2 here)
        crv4 = 4'b0010; rrdy4 = 1'b0; rv4 = 1'b1; rid4 = 2'd0; rd4 = 64'h77; crr4 = '0;
        #1;
        check("pre-reset core_req_ready", 64'(cqr4), 64'h2);
        tick();
        check("pre-reset req_id", 64'(qid4), 64'h1);
        check("pre-reset core_resp_valid", 64'(crsv4), 64'h1);
        crv4 = '0; rv4 = 1'b0;
        tick();
        check("pre-reset req held", 64'(qv4), 64'h1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid reset req_valid", 64'(qv4), 64'h0);
        check("mid reset core_resp_valid", 64'(crsv4), 64'h0);
        check("mid reset n3 bad_id", 64'(bad3), 64'h0);
        cyc4("post reset grant", 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 64'hA0);
        cyc4("post reset idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
